// File: rtl/sme_match_pkg.sv
// Shared types and width helpers for the SME match-drain stage.
package sme_match_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SCAN  = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Lane index width and FIFO level width as functions of the block parameters.
  function automatic int lane_w(input int n_lanes);
    return $clog2(n_lanes);
  endfunction

  function automatic int lvl_w(input int fifo_depth);
    return $clog2(fifo_depth) + 1;
  endfunction

endpackage

// File: rtl/sme_match_fifo.sv
// Synchronous show-ahead FIFO; a write while full is accepted when a read happens in the same cycle.
module sme_match_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sme_match_drain.sv
// Buffers N-lane match words and presents non-zero rule IDs one at a time, lowest lane first.
module sme_match_drain
  import sme_match_pkg::*;
#(
  parameter int N_LANES    = 8,
  parameter int ID_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_LANES*ID_WIDTH-1:0]     in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic                            reload,
  input  logic                            match_release,
  output logic                            match_valid,
  output logic [ID_WIDTH-1:0]             match_rule_ID,
  output logic [lane_w(N_LANES)-1:0]      match_lane,
  output logic                            pkt_done,
  output logic [N_LANES-1:0]              pending_mask,
  output logic [CNT_WIDTH-1:0]            match_count,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic                            overflow,
  output logic [lvl_w(FIFO_DEPTH)-1:0]    fifo_level
);

  localparam int LANE_W = lane_w(N_LANES);
  localparam int DW     = N_LANES * ID_WIDTH;

  state_t            state, next_state;
  logic [DW:0]       fifo_rd;
  logic              fifo_full, fifo_empty, fifo_wr;
  logic [DW-1:0]     hold_data;
  logic              hold_last;
  logic              pop, present, release_ok, retire, drop;
  logic [LANE_W-1:0] sel_lane;
  logic [N_LANES-1:0] load_mask;

  assign fifo_wr = in_valid && !reload && (!fifo_full || pop);
  assign drop    = in_valid && !reload && fifo_full && !pop;

  sme_match_fifo #(
    .WIDTH(DW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (reload),
    .wr_en   (fifo_wr),
    .wr_data ({in_last, in_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Descending scan so the lowest set lane is the one left standing.
  always_comb begin
    sel_lane = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (pending_mask[i]) sel_lane = i[LANE_W-1:0];
    end
  end

  always_comb begin
    load_mask = '0;
    for (int k = 0; k < N_LANES; k++) begin
      load_mask[k] = |fifo_rd[k*ID_WIDTH +: ID_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state <= EMPTY;
    else if (reload) state <= EMPTY;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    present    = 1'b0;
    release_ok = 1'b0;
    retire     = 1'b0;
    case (state)
      EMPTY: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (|pending_mask) begin
          present    = 1'b1;
          next_state = SHOW;
        end else begin
          retire     = 1'b1;
          pop        = !fifo_empty;
          next_state = fifo_empty ? EMPTY : SCAN;
        end
      end
      SHOW: begin
        if (match_release) begin
          release_ok = 1'b1;
          next_state = SCAN;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data     <= '0;
      hold_last     <= 1'b0;
      pending_mask  <= '0;
      match_valid   <= 1'b0;
      match_rule_ID <= '0;
      match_lane    <= '0;
      pkt_done      <= 1'b0;
      match_count   <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else if (reload) begin
      hold_data     <= '0;
      hold_last     <= 1'b0;
      pending_mask  <= '0;
      match_valid   <= 1'b0;
      match_rule_ID <= '0;
      match_lane    <= '0;
      pkt_done      <= 1'b0;
      match_count   <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      pkt_done <= retire && hold_last;
      if (pop) begin
        hold_data    <= fifo_rd[DW-1:0];
        hold_last    <= fifo_rd[DW];
        pending_mask <= load_mask;
      end
      if (present) begin
        match_valid   <= 1'b1;
        match_lane    <= sel_lane;
        match_rule_ID <= hold_data[sel_lane*ID_WIDTH +: ID_WIDTH];
      end
      if (release_ok) begin
        match_valid              <= 1'b0;
        pending_mask[match_lane] <= 1'b0;
        if (match_count != '1) match_count <= match_count + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sme_match_drain.sv
// Directed table-driven bench for sme_match_drain with hand-written multi-cycle corner sequences.
module tb_sme_match_drain;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         reload = 1'b0;
  logic         match_release = 1'b0;
  logic         match_valid;
  logic [15:0]  match_rule_ID;
  logic [2:0]   match_lane;
  logic         pkt_done;
  logic [7:0]   pending_mask;
  logic [15:0]  match_count;
  logic [15:0]  drop_count;
  logic         overflow;
  logic [2:0]   fifo_level;

  int tests = 0;
  int fails = 0;

  sme_match_drain dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .reload        (reload),
    .match_release (match_release),
    .match_valid   (match_valid),
    .match_rule_ID (match_rule_ID),
    .match_lane    (match_lane),
    .pkt_done      (pkt_done),
    .pending_mask  (pending_mask),
    .match_count   (match_count),
    .drop_count    (drop_count),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         vld;
    logic         last;
    logic         rld;
    logic         rel;
    logic         ev;
    logic [15:0]  eid;
    logic [2:0]   elane;
    logic         epkt;
    logic [7:0]   emask;
    logic [15:0]  ecnt;
    logic [2:0]   elvl;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then let one rising edge pass and settle.
  task automatic applyStimulus(input logic [127:0] d, input logic v, input logic l,
                               input logic rl, input logic rel);
    in_data       = d;
    in_valid      = v;
    in_last       = l;
    reload        = rl;
    match_release = rel;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, 32'(match_valid), 0);
    checkOutput({tag, "_id"}, 32'(match_rule_ID), 0);
    checkOutput({tag, "_lane"}, 32'(match_lane), 0);
    checkOutput({tag, "_pkt"}, 32'(pkt_done), 0);
    checkOutput({tag, "_mask"}, 32'(pending_mask), 0);
    checkOutput({tag, "_cnt"}, 32'(match_count), 0);
    checkOutput({tag, "_drop"}, 32'(drop_count), 0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 0);
    checkOutput({tag, "_lvl"}, 32'(fifo_level), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [127:0] w1;
    logic [127:0] z;
    logic [127:0] w;
    w1 = {16'h0056, 16'h0, 16'h0, 16'h0, 16'h0034, 16'h0, 16'h0012, 16'h0};
    z  = '0;

    //             data vld last rld rel | ev  eid     lane pkt mask   cnt lvl
    vecs[0]  = '{w1, 1, 1, 0, 0,  0, 16'h0,  0, 0, 8'h00, 0, 1};
    vecs[1]  = '{z,  0, 0, 0, 0,  0, 16'h0,  0, 0, 8'h8A, 0, 0};
    vecs[2]  = '{z,  0, 0, 0, 0,  1, 16'h12, 1, 0, 8'h8A, 0, 0};
    vecs[3]  = '{z,  0, 0, 0, 1,  0, 16'h0,  0, 0, 8'h88, 1, 0};
    vecs[4]  = '{z,  0, 0, 0, 0,  1, 16'h34, 3, 0, 8'h88, 1, 0};
    vecs[5]  = '{z,  0, 0, 0, 1,  0, 16'h0,  0, 0, 8'h80, 2, 0};
    vecs[6]  = '{z,  0, 0, 0, 0,  1, 16'h56, 7, 0, 8'h80, 2, 0};
    vecs[7]  = '{z,  0, 0, 0, 1,  0, 16'h0,  0, 0, 8'h00, 3, 0};
    vecs[8]  = '{z,  0, 0, 0, 0,  0, 16'h0,  0, 1, 8'h00, 3, 0};
    vecs[9]  = '{z,  0, 0, 0, 0,  0, 16'h0,  0, 0, 8'h00, 3, 0};
    vecs[10] = '{z,  1, 1, 0, 0,  0, 16'h0,  0, 0, 8'h00, 3, 1};
    vecs[11] = '{z,  0, 0, 0, 0,  0, 16'h0,  0, 0, 8'h00, 3, 0};
    vecs[12] = '{z,  0, 0, 0, 1,  0, 16'h0,  0, 1, 8'h00, 3, 0};
    vecs[13] = '{z,  0, 0, 0, 1,  0, 16'h0,  0, 0, 8'h00, 3, 0};

    #1 rst = 1'b1;
    #2;
    checkResetValues("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].data, vecs[i].vld, vecs[i].last, vecs[i].rld, vecs[i].rel);
      checkOutput($sformatf("v%0d_valid", i), 32'(match_valid), 32'(vecs[i].ev));
      checkOutput($sformatf("v%0d_pkt", i), 32'(pkt_done), 32'(vecs[i].epkt));
      checkOutput($sformatf("v%0d_mask", i), 32'(pending_mask), 32'(vecs[i].emask));
      checkOutput($sformatf("v%0d_cnt", i), 32'(match_count), 32'(vecs[i].ecnt));
      checkOutput($sformatf("v%0d_lvl", i), 32'(fifo_level), 32'(vecs[i].elvl));
      if (vecs[i].ev) begin
        checkOutput($sformatf("v%0d_id", i), 32'(match_rule_ID), 32'(vecs[i].eid));
        checkOutput($sformatf("v%0d_lane", i), 32'(match_lane), 32'(vecs[i].elane));
      end
    end

    // Six back-to-back words with no release: four buffered, one held, one dropped.
    for (int i = 0; i < 6; i++) begin
      w = '0;
      w[15:0] = 16'h0100 + 16'(i);
      applyStimulus(w, 1, 0, 0, 0);
    end
    checkOutput("ovf_drop", 32'(drop_count), 1);
    checkOutput("ovf_flag", 32'(overflow), 1);
    checkOutput("ovf_lvl", 32'(fifo_level), 4);
    checkOutput("ovf_valid", 32'(match_valid), 1);
    checkOutput("ovf_id", 32'(match_rule_ID), 32'h100);

    // Presentation must stay frozen while the consumer withholds release.
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0, 0, 0, 0, 0);
      checkOutput($sformatf("hold%0d_valid", i), 32'(match_valid), 1);
      checkOutput($sformatf("hold%0d_id", i), 32'(match_rule_ID), 32'h100);
      checkOutput($sformatf("hold%0d_lane", i), 32'(match_lane), 0);
      checkOutput($sformatf("hold%0d_cnt", i), 32'(match_count), 3);
    end

    applyStimulus('0, 0, 0, 0, 1);
    checkOutput("rel_valid", 32'(match_valid), 0);
    checkOutput("rel_cnt", 32'(match_count), 4);
    applyStimulus('0, 0, 0, 0, 0);
    checkOutput("retire_lvl", 32'(fifo_level), 3);
    checkOutput("retire_pkt", 32'(pkt_done), 0);
    applyStimulus('0, 0, 0, 0, 0);
    checkOutput("next_valid", 32'(match_valid), 1);
    checkOutput("next_id", 32'(match_rule_ID), 32'h101);

    // Reload in SHOW together with an incoming word.
    w = '0;
    w[15:0] = 16'h0BAD;
    applyStimulus(w, 1, 1, 1, 0);
    checkOutput("rld_valid", 32'(match_valid), 0);
    checkOutput("rld_lvl", 32'(fifo_level), 0);
    checkOutput("rld_cnt", 32'(match_count), 0);
    checkOutput("rld_drop", 32'(drop_count), 0);
    checkOutput("rld_ovf", 32'(overflow), 0);
    checkOutput("rld_mask", 32'(pending_mask), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, 0, 0, 0, 0);
      checkOutput($sformatf("rld_idle%0d_valid", i), 32'(match_valid), 0);
      checkOutput($sformatf("rld_idle%0d_lvl", i), 32'(fifo_level), 0);
    end

    w = '0;
    w[47:32] = 16'h0077;
    applyStimulus(w, 1, 0, 0, 0);
    checkOutput("post_rld_lvl", 32'(fifo_level), 1);
    applyStimulus('0, 0, 0, 0, 0);
    checkOutput("post_rld_load_valid", 32'(match_valid), 0);
    applyStimulus('0, 0, 0, 0, 0);
    checkOutput("post_rld_valid", 32'(match_valid), 1);
    checkOutput("post_rld_id", 32'(match_rule_ID), 32'h77);
    checkOutput("post_rld_lane", 32'(match_lane), 2);

    // Buffer two more words, then assert rst between clock edges.
    w = '0;
    w[15:0] = 16'h00A1;
    applyStimulus(w, 1, 1, 0, 0);
    w[15:0] = 16'h00A2;
    applyStimulus(w, 1, 1, 0, 0);
    checkOutput("pre_rst_lvl", 32'(fifo_level), 2);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    #1 rst = 1'b1;
    #1;
    checkResetValues("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rst_hold%0d_pkt", i), 32'(pkt_done), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus('0, 0, 0, 0, 0);
      checkOutput($sformatf("post_rst%0d_pkt", i), 32'(pkt_done), 0);
      checkOutput($sformatf("post_rst%0d_valid", i), 32'(match_valid), 0);
      checkOutput($sformatf("post_rst%0d_lvl", i), 32'(fifo_level), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sme_match_drain.md
# sme_match_drain

Parametrised match-drain stage between the port-group output of the Pigasus SME and the core-facing match interface. It buffers N-lane match words (one rule ID per lane, 0 = no match) in a small FIFO, then presents the non-zero IDs one at a time, lowest lane first, under a valid/release handshake. It also reports per-packet completion, release and drop statistics, and overflow. It generalises the fixed 8×16-bit match selector with configurable lane count, ID width and depth, true per-lane valids, a lane index output, and loss accounting.

## Interface
- N_LANES, 8: match lanes per input word; must be ≥2.
- ID_WIDTH, 16: rule ID width.
- FIFO_DEPTH, 4: input word buffer depth; a power of two, ≥2.
- CNT_WIDTH, 16: width of the statistics counters.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  N_LANES*ID_WIDTH  match word; lane k is bits [k*ID_WIDTH +: ID_WIDTH].
- in_valid  in  1  word strobe. There is no ready; the producer is never stalled.
- in_last  in  1  word is the final match word of a packet.
- reload  in  1  synchronous flush for a new packet or slot.
- match_release  in  1  consumer acknowledges the presented match.
- match_valid  out  1  a match is presented.
- match_rule_ID  out  ID_WIDTH  presented rule ID.
- match_lane  out  $clog2(N_LANES)  lane of the presented ID.
- pkt_done  out  1  one-cycle pulse when a word marked last is fully drained.
- pending_mask  out  N_LANES  lanes of the held word not yet released.
- match_count  out  CNT_WIDTH  released matches; saturates.
- drop_count  out  CNT_WIDTH  words dropped while the FIFO was full; saturates.
- overflow  out  1  sticky; set on the first drop.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Write path: when in_valid=1 and the FIFO is not full, or is full but popping in the same cycle, the word and in_last are written. Otherwise the word is dropped, drop_count increments and overflow sets.
- Hold register: hold_data, hold_last, and pending_mask[k] = (lane k ID ≠ 0), all captured on load.
- FSM has three states: EMPTY, SCAN, SHOW.
- EMPTY: if the FIFO is non-empty, pop into the hold register and go to SCAN.
- SCAN, pending_mask ≠ 0: register the lowest set lane into match_lane and match_rule_ID, set match_valid=1, go to SHOW.
- SCAN, pending_mask = 0 (retire): pulse pkt_done if hold_last. Then, if the FIFO is non-empty, pop the next word and stay in SCAN; otherwise go to EMPTY.
- SHOW: on match_release, clear pending_mask[match_lane], set match_valid=0, increment match_count, and go to SCAN.
- match_release is ignored whenever match_valid=0.
- reload has priority over every other event. It empties the FIFO and hold register, forces EMPTY, and clears match_valid, pending_mask, match_count, drop_count and overflow. A word arriving in the same cycle as reload is discarded and is not counted as a drop.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values: match_valid=0, match_rule_ID=0, match_lane=0, pkt_done=0, pending_mask=0, match_count=0, drop_count=0, overflow=0, fifo_level=0, FSM=EMPTY. These values apply immediately on rst assertion.
- The FIFO is show-ahead: data is visible on the cycle after the write.
- Latency, empty block: for a word accepted at edge E, the hold register loads at E+1 and match_valid rises at E+2.
- Release to next presentation: release sampled at edge R gives match_valid=0 after R and the next match valid after R+1. This is one bubble per match, so peak throughput is one match per 2 cycles.
- Drain/turnaround: after the final release at R, the word retires at R+1. pkt_done (if hold_last) is high during the cycle after R+1, and the next word is loaded at that same R+1 edge.
- An all-zero word occupies SCAN for exactly one cycle and produces no match_valid.
- match_rule_ID and match_lane are stable for as long as match_valid=1.
- rst may assert mid-handshake: all state clears asynchronously, and no pkt_done is issued.

## Structure
- Package sme_match_pkg holds the FSM state enum (EMPTY, SCAN, SHOW) and the localparams LANE_W = $clog2(N_LANES) and LVL_W = $clog2(FIFO_DEPTH)+1, supplied as functions of the parameters.
- Sub-module sme_match_fifo: synchronous show-ahead FIFO.
  - Width is N_LANES*ID_WIDTH+1.
  - Ports: clear, full, empty and level.
  - Reset: asynchronous.
  - Simultaneous write and read when full is accepted.
- Lowest-set-lane select is a combinational priority loop over pending_mask, inside the top module.

## Test plan
- Reset then single word, lanes 0..7 = {0, 0x12, 0, 0x34, 0, 0, 0, 0x56}, last=1, released immediately each time → IDs 0x12/lane 1, 0x34/lane 3, 0x56/lane 7 in order; match_valid rises 2 cycles after acceptance; pkt_done pulses once; match_count=3.
- All-zero word with last=1 → no match_valid; pkt_done one cycle after the load.
- FIFO_DEPTH=4, 6 back-to-back words, no release → 5 accepted (4 in the FIFO, 1 held); drop_count=1; overflow=1; fifo_level=4.
- Hold match_release low for 10 cycles → match_rule_ID and match_lane stable; match_count unchanged. A release while match_valid=0 has no effect.
- reload asserted in SHOW in the same cycle as in_valid → next cycle match_valid=0, fifo_level=0, counters=0, overflow=0, FSM=EMPTY.
- Async rst asserted mid-SHOW with 2 words buffered → outputs reach reset values with no clock edge; no pkt_done.
